// File: rtl/cont_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cont_poll_sequencer
// Brief    : Serial game-controller poll sequencer. Drives latch and shift
//            clock, samples contRead and delivers an active-high button word.
//            Optional build macro CONT_DEBOUNCE_EN: publish only when two
//            consecutive poll words agree.
// Revision : 1.0 - initial release
// ============================================================================
module cont_poll_sequencer #(
    parameter int NUM_BITS    = 8,
    parameter int LATCH_CYC   = 480,
    parameter int HALF_PER    = 240,
    parameter int POLL_PERIOD = 666667
) (
    input  logic                PCLK,
    input  logic                MSS_RESET_N,
    input  logic                poll_en,
    input  logic                poll_req,
    input  logic                contRead,
    output logic                contWrite,
    output logic                contCLK,
    output logic [NUM_BITS-1:0] buttons,
    output logic                buttons_valid,
    output logic                busy
);

    localparam int c_PHASE_MAX = (LATCH_CYC > HALF_PER) ? LATCH_CYC : HALF_PER;
    localparam int c_PHASE_W   = $clog2(c_PHASE_MAX + 1);
    localparam int c_PERIOD_W  = $clog2(POLL_PERIOD + 1);
    localparam int c_BIT_W     = $clog2(NUM_BITS);

    localparam logic [c_PHASE_W-1:0]  c_LATCH_LAST  = c_PHASE_W'(LATCH_CYC - 1);
    localparam logic [c_PHASE_W-1:0]  c_HALF_LAST   = c_PHASE_W'(HALF_PER - 1);
    localparam logic [c_PERIOD_W-1:0] c_PERIOD_LAST = c_PERIOD_W'(POLL_PERIOD - 1);
    localparam logic [c_BIT_W-1:0]    c_BIT_LAST    = c_BIT_W'(NUM_BITS - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LATCH = 3'd1;
    localparam logic [2:0] c_HIGH  = 3'd2;
    localparam logic [2:0] c_LOW   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [2:0]            w_nextState;
    logic [c_PHASE_W-1:0]  r_phaseCnt;
    logic [c_PHASE_W-1:0]  w_phaseLast;
    logic [c_BIT_W-1:0]    r_bitCnt;
    logic [NUM_BITS-1:0]   r_shift;
    logic [c_PERIOD_W-1:0] r_periodCnt;
    logic                  r_pending;
    logic                  r_syncMeta;
    logic                  r_syncRead;
    logic                  w_tick;
    logic                  w_trigger;
    logic                  w_accept;
    logic                  w_phaseEnd;
    logic                  w_lastBit;
    logic                  w_wordDone;

    // contRead is asynchronous to PCLK; preset high so a missing controller reads as released
    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_syncMeta <= 1'b1;
            r_syncRead <= 1'b1;
        end else begin
            r_syncMeta <= contRead;
            r_syncRead <= r_syncMeta;
        end
    end

    assign w_tick    = poll_en && (r_periodCnt == c_PERIOD_LAST);
    assign w_trigger = poll_req || w_tick;

    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_periodCnt <= '0;
        end else if (!poll_en || w_tick) begin
            r_periodCnt <= '0;
        end else begin
            r_periodCnt <= r_periodCnt + c_PERIOD_W'(1);
        end
    end

    assign w_accept    = (r_state == c_IDLE) && (w_trigger || r_pending);
    assign w_phaseLast = (r_state == c_LATCH) ? c_LATCH_LAST : c_HALF_LAST;
    assign w_phaseEnd  = (r_phaseCnt == w_phaseLast);
    assign w_lastBit   = (r_bitCnt == c_BIT_LAST);
    assign w_wordDone  = (r_state == c_LOW) && w_phaseEnd && w_lastBit;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_accept)   w_nextState = c_LATCH;
            c_LATCH: if (w_phaseEnd) w_nextState = c_HIGH;
            c_HIGH:  if (w_phaseEnd) w_nextState = c_LOW;
            c_LOW:   if (w_phaseEnd) w_nextState = w_lastBit ? c_DONE : c_HIGH;
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Pad outputs are decoded from the next state so every output is a flop
    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_state    <= c_IDLE;
            r_phaseCnt <= '0;
            r_bitCnt   <= '0;
            contWrite  <= 1'b0;
            contCLK    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            contWrite <= (w_nextState == c_LATCH);
            contCLK   <= (w_nextState != c_LOW);
            busy      <= (w_nextState != c_IDLE);

            if ((w_nextState != r_state) || (r_state == c_IDLE)) begin
                r_phaseCnt <= '0;
            end else begin
                r_phaseCnt <= r_phaseCnt + c_PHASE_W'(1);
            end

            if (r_state == c_IDLE) begin
                r_bitCnt <= '0;
            end else if ((r_state == c_LOW) && w_phaseEnd && !w_lastBit) begin
                r_bitCnt <= r_bitCnt + c_BIT_W'(1);
            end
        end
    end

    // A trigger that arrives while a poll is in flight is remembered once
    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b0;
        end else if ((r_state != c_IDLE) && w_trigger) begin
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_shift <= '0;
        end else if ((r_state == c_HIGH) && w_phaseEnd) begin
            r_shift[r_bitCnt] <= ~r_syncRead;
        end
    end

`ifdef CONT_DEBOUNCE_EN
    logic [NUM_BITS-1:0] r_prevRaw;

    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            r_prevRaw     <= '0;
            buttons       <= '0;
            buttons_valid <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            if (w_wordDone) begin
                r_prevRaw <= r_shift;
                if (r_shift == r_prevRaw) begin
                    buttons       <= r_shift;
                    buttons_valid <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge PCLK or negedge MSS_RESET_N) begin
        if (!MSS_RESET_N) begin
            buttons       <= '0;
            buttons_valid <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            if (w_wordDone) begin
                buttons       <= r_shift;
                buttons_valid <= 1'b1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cont_poll_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cont_poll_sequencer
// Brief    : Self-checking bench for cont_poll_sequencer with a cycle-count
//            reference model and a shift-register controller model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cont_poll_sequencer;

    localparam int NB  = 8;
    localparam int LC  = 4;
    localparam int HP  = 4;
    localparam int PP  = 200;
    localparam int LAT = LC + 2 * NB * HP + 1;

    logic          PCLK        = 1'b0;
    logic          MSS_RESET_N = 1'b0;
    logic          poll_en     = 1'b0;
    logic          poll_req    = 1'b0;
    logic          contRead    = 1'b1;
    logic          contWrite;
    logic          contCLK;
    logic [NB-1:0] buttons;
    logic          buttons_valid;
    logic          busy;

    int checkCnt = 0;
    int errCnt   = 0;
    int cyc      = 0;

    always #5 PCLK = ~PCLK;

    cont_poll_sequencer #(
        .NUM_BITS    (NB),
        .LATCH_CYC   (LC),
        .HALF_PER    (HP),
        .POLL_PERIOD (PP)
    ) u_dut (
        .PCLK          (PCLK),
        .MSS_RESET_N   (MSS_RESET_N),
        .poll_en       (poll_en),
        .poll_req      (poll_req),
        .contRead      (contRead),
        .contWrite     (contWrite),
        .contCLK       (contCLK),
        .buttons       (buttons),
        .buttons_valid (buttons_valid),
        .busy          (busy)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Controller model: latch loads the word, each rising contCLK shifts the next bit out
    logic [NB-1:0] curRaw   = '1;
    logic [NB-1:0] ctrlWord = '1;
    int            ctrlIdx  = NB;
    logic          prevW    = 1'b0;
    logic          prevC    = 1'b1;
    logic [NB-1:0] ctrlQ[$];

    initial forever begin
        @(negedge PCLK);
        if (!MSS_RESET_N) begin
            prevW   = 1'b0;
            prevC   = 1'b1;
            ctrlIdx = NB;
        end else begin
            if (contWrite && !prevW) begin
                ctrlWord = curRaw;
                ctrlIdx  = 0;
                ctrlQ.push_back(curRaw);
            end else if (contCLK && !prevC && !contWrite) begin
                ctrlIdx++;
            end
            prevW = contWrite;
            prevC = contCLK;
        end
        contRead = (ctrlIdx < NB) ? ctrlWord[ctrlIdx] : 1'b1;
    end

    // Reference model: one poll occupies a fixed number of cycles after acceptance
    bit            active     = 1'b0;
    bit            pending    = 1'b0;
    int            accCyc     = 0;
    int            cnt        = 0;
    logic [NB-1:0] expButtons = '0;
    logic [NB-1:0] prevWord   = '0;

    function automatic bit modelIdle();
        return !active || (cyc - accCyc > LAT);
    endfunction

    task automatic step(input logic req, input logic en);
        int            off;
        logic          expValid;
        logic          lowPhase;
        logic [NB-1:0] word;
        bit            trig;
        bit            idle;
        off      = cyc - accCyc;
        expValid = 1'b0;
        if (active && off == LAT) begin
            checkEq("latchCount", ctrlQ.size(), 1);
            word = (ctrlQ.size() > 0) ? ~ctrlQ.pop_front() : '0;
`ifdef CONT_DEBOUNCE_EN
            expValid = (word == prevWord);
            prevWord = word;
`else
            expValid = 1'b1;
`endif
            if (expValid) expButtons = word;
        end
        lowPhase = active && off > LC && off < LAT && (((off - LC - 1) % (2 * HP)) >= HP);
        checkEq("busy", busy, active && off >= 1 && off <= LAT);
        checkEq("contWrite", contWrite, active && off >= 1 && off <= LC);
        checkEq("contCLK", contCLK, !lowPhase);
        checkEq("valid", buttons_valid, expValid);
        checkEq("buttons", buttons, expButtons);

        poll_req = req;
        poll_en  = en;
        trig = req || (en && cnt == PP - 1);
        idle = modelIdle();
        if (idle && (trig || pending)) begin
            active  = 1'b1;
            accCyc  = cyc;
            pending = 1'b0;
        end else if (!idle && trig) begin
            pending = 1'b1;
        end
        cnt = en ? ((cnt == PP - 1) ? 0 : cnt + 1) : 0;
        @(posedge PCLK);
        #1;
        cyc++;
    endtask

    task automatic applyReset();
        MSS_RESET_N = 1'b0;
        poll_req    = 1'b0;
        poll_en     = 1'b0;
        #2;
        checkEq("rstContWrite", contWrite, 1'b0);
        checkEq("rstContCLK", contCLK, 1'b1);
        checkEq("rstBusy", busy, 1'b0);
        checkEq("rstValid", buttons_valid, 1'b0);
        checkEq("rstButtons", buttons, '0);
        repeat (2) @(posedge PCLK);
        #1;
        MSS_RESET_N = 1'b1;
        active     = 1'b0;
        pending    = 1'b0;
        cnt        = 0;
        expButtons = '0;
        prevWord   = '0;
        ctrlQ.delete();
        cyc++;
    endtask

    logic [NB-1:0] pool [4];
    logic [NB-1:0] dbw  [3];
    logic          randEn;

    initial begin
        pool[0] = 8'hFF; pool[1] = 8'h00; pool[2] = 8'h5E; pool[3] = 8'hA5;
        dbw[0]  = ~8'h01; dbw[1] = ~8'h03; dbw[2] = ~8'h03;

        repeat (3) @(posedge PCLK);
        #1;
        checkEq("initContWrite", contWrite, 1'b0);
        checkEq("initContCLK", contCLK, 1'b1);
        checkEq("initBusy", busy, 1'b0);
        checkEq("initButtons", buttons, '0);
        MSS_RESET_N = 1'b1;

        // Single requested poll returning 0x5E on the wire
        curRaw = 8'h5E;
        step(1'b1, 1'b0);
        repeat (75) step(1'b0, 1'b0);

        // Three sequential polls for the debounce sequence
        for (int i = 0; i < 3; i++) begin
            curRaw = dbw[i];
            step(1'b1, 1'b0);
            repeat (75) step(1'b0, 1'b0);
        end

        // Periodic polling only
        curRaw = 8'hA5;
        repeat (3 * PP + 50) step(1'b0, 1'b1);
        repeat (80) step(1'b0, 1'b0);

        // Request while busy, then again while pending
        curRaw = 8'h3C;
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (2 * LAT + 20) step(1'b0, 1'b0);

        // Request coincident with a period tick
        for (int i = 0; i < 2 * PP && !(cnt == PP - 1 && modelIdle()); i++) step(1'b0, 1'b1);
        checkEq("tickAlign", cnt, PP - 1);
        step(1'b1, 1'b1);
        repeat (2 * PP) step(1'b0, 1'b0);

        // Randomised traffic
        randEn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) randEn = ~randEn;
            if ($urandom_range(0, 299) == 0) curRaw = pool[$urandom_range(0, 3)];
            step($urandom_range(0, 59) == 0, randEn);
        end
        repeat (LAT + 5) step(1'b0, 1'b0);

        // Reset in the middle of a poll discards it
        curRaw = 8'h33;
        step(1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b0);
        applyReset();
        repeat (100) step(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
`default_nettype wire
